tinycpu_mem_resp: RTL and testbench

TINYCPU_MEM_RESP -- requirements
Module: tinycpu_mem_resp

---
 rtl/tinycpu_pkg.sv | 21 ++
 rtl/tinycpu_ram.sv | 39 +++
 rtl/tinycpu_mem_resp.sv | 157 +++++++++++++++
 tb/tb_tinycpu_mem_resp.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tinycpu_pkg.sv
// tinycpu_pkg
//   Shared constants and types for the tinycpu memory responder:
//   address/data widths, wait-counter width and the FSM state encoding.
package tinycpu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;   // holds WAIT_CYCLES-1 for WAIT_CYCLES in 0..15

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  // Value loaded into the wait down-counter on acceptance.
  function automatic logic [CNT_W-1:0] wait_load(input int wait_cycles);
    return (wait_cycles > 0) ? CNT_W'(wait_cycles - 1) : '0;
  endfunction

endpackage

// File: rtl/tinycpu_ram.sv
// tinycpu_ram
//   DEPTH x 8 storage array, no reset. One asynchronous read port and two
//   synchronous write ports; the loader port wins when both write the same
//   word on the same edge.
// Ports:
//   clk                                   clock
//   rd_addr / rd_data                     combinational read port
//   cpu_we / cpu_addr / cpu_wdata         CPU-side write port
//   ld_we / ld_addr / ld_wdata            host loader write port (priority)
module tinycpu_ram
  import tinycpu_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              cpu_we,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              ld_we,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_wdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Read sees pre-edge contents, so a read completing alongside a write to
  // the same word returns the old value.
  assign rd_data = mem_q[rd_addr];

  // Loader write is issued last so it overrides a same-address CPU write.
  always_ff @(posedge clk) begin
    if (cpu_we) mem_q[cpu_addr] <= cpu_wdata;
    if (ld_we)  mem_q[ld_addr]  <= ld_wdata;
  end

endmodule

// File: rtl/tinycpu_mem_resp.sv
// tinycpu_mem_resp
//   Wait-state memory responder for a tiny CPU. A request accepted in IDLE
//   latches addr/we/wdata, spends WAIT_CYCLES cycles in WAIT, then pulses
//   ack for one cycle in ACK. Memory access happens on the edge entering ACK.
//   A host loader can write the array on any edge, including during reset.
// Ports:
//   clk, reset (async, active-low)
//   req, we, addr, wdata     CPU request side
//   rdata, ack, busy         CPU response side (all registered)
//   ld_en, ld_addr, ld_data  host preload port
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | no transaction; req samples and latches a new request
//   WAIT  | counting down wait states (cnt_q reaches 0 -> ACK)
//   ACK   | ack pulse; always returns to IDLE
module tinycpu_mem_resp
  import tinycpu_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int DEPTH       = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = wait_load(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;

  logic              enter_ack;
  logic              txn_we;
  logic [ADDR_W-1:0] txn_addr;
  logic [DATA_W-1:0] txn_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              unused_hi;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    enter_ack = 1'b0;
    // With zero wait states the access happens on the acceptance edge, so
    // the live request fields are used instead of the not-yet-latched ones.
    txn_we    = we_q;
    txn_addr  = addr_q;
    txn_wdata = wdata_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d    = addr;
          we_d      = we;
          wdata_d   = wdata;
          txn_we    = we;
          txn_addr  = addr;
          txn_wdata = wdata;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d   = ACK;
            enter_ack = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d   = ACK;
          enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (enter_ack && !txn_we) rdata_d = mem_rdata;
    ack_d  = enter_ack;
    busy_d = (state_d != IDLE);
  end

  // Gated by reset so a transaction interrupted by reset never writes memory.
  assign mem_we = enter_ack & txn_we & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  tinycpu_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .rd_addr   (txn_addr[AW-1:0]),
    .rd_data   (mem_rdata),
    .cpu_we    (mem_we),
    .cpu_addr  (txn_addr[AW-1:0]),
    .cpu_wdata (txn_wdata),
    .ld_we     (ld_en),
    .ld_addr   (ld_addr[AW-1:0]),
    .ld_wdata  (ld_data)
  );

  // Address bits above AW are deliberately dropped so addresses wrap.
  assign unused_hi = ^{addr_q, ld_addr};

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_tinycpu_mem_resp.sv
// Bench: three responders share one clock and reset.
//   dut 0: WAIT_CYCLES=1, DEPTH=256
//   dut 1: WAIT_CYCLES=0, DEPTH=256
//   dut 2: WAIT_CYCLES=3, DEPTH=16
module tb_tinycpu_mem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       req     [3];
  logic       we      [3];
  logic       ld_en   [3];
  logic       ack     [3];
  logic       busy    [3];
  logic [7:0] addr    [3];
  logic [7:0] wdata   [3];
  logic [7:0] ld_addr [3];
  logic [7:0] ld_data [3];
  logic [7:0] rdata   [3];

  int checks = 0;
  int errors = 0;

  tinycpu_mem_resp #(.WAIT_CYCLES(1), .DEPTH(256)) u_dut0 (
    .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0]),
    .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0]));

  tinycpu_mem_resp #(.WAIT_CYCLES(0), .DEPTH(256)) u_dut1 (
    .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1]),
    .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1]));

  tinycpu_mem_resp #(.WAIT_CYCLES(3), .DEPTH(16)) u_dut2 (
    .clk(clk), .reset(reset), .req(req[2]), .we(we[2]), .addr(addr[2]),
    .wdata(wdata[2]), .rdata(rdata[2]), .ack(ack[2]), .busy(busy[2]),
    .ld_en(ld_en[2]), .ld_addr(ld_addr[2]), .ld_data(ld_data[2]));

  typedef struct packed {
    logic       w;
    logic [7:0] a;
    logic [7:0] wd;
    logic [7:0] exp;   // rdata expected after the transaction
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input int d, input logic [7:0] a, input logic [7:0] v);
    @(negedge clk);
    ld_en[d] = 1'b1; ld_addr[d] = a; ld_data[d] = v;
    @(negedge clk);
    ld_en[d] = 1'b0;
  endtask

  // One transaction: checks ack latency, busy cycles and the one-cycle pulse.
  // Request fields are scrambled right after acceptance.
  task automatic txn(input int d, input logic w, input logic [7:0] a,
                     input logic [7:0] wd, input int exp_lat, input string name);
    int lat;
    int busy_n;
    bit seen;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    @(posedge clk);
    lat = 0; busy_n = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      req[d] = 1'b0; we[d] = ~w; addr[d] = ~a; wdata[d] = ~wd;
      if (busy[d]) busy_n++;
      if (ack[d]) seen = 1'b1;
    end
    chk({name, "_lat"}, seen ? lat : 999, exp_lat);
    chk({name, "_busy"}, busy_n, exp_lat);
    @(negedge clk);
    chk({name, "_pulse"}, {ack[d], busy[d]}, 2'b00);
  endtask

  int         n_ack;
  int         ack_at [3];
  logic [7:0] ack_rd [3];
  logic       busy3, busy6;
  bit         seen_ack;

  initial begin
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req[d] = 0; we[d] = 0; addr[d] = 0; wdata[d] = 0;
      ld_en[d] = 0; ld_addr[d] = 0; ld_data[d] = 0;
    end

    vecs[0]  = '{1'b1, 8'h01, 8'h11, 8'hA5};
    vecs[1]  = '{1'b1, 8'h02, 8'h22, 8'hA5};
    vecs[2]  = '{1'b1, 8'h03, 8'h33, 8'hA5};
    vecs[3]  = '{1'b0, 8'h01, 8'h00, 8'h11};
    vecs[4]  = '{1'b0, 8'h02, 8'h00, 8'h22};
    vecs[5]  = '{1'b1, 8'h02, 8'h5A, 8'h22};
    vecs[6]  = '{1'b0, 8'h02, 8'h00, 8'h5A};
    vecs[7]  = '{1'b0, 8'h03, 8'h00, 8'h33};
    vecs[8]  = '{1'b1, 8'hFF, 8'hC3, 8'h33};
    vecs[9]  = '{1'b0, 8'hFF, 8'h00, 8'hC3};
    vecs[10] = '{1'b0, 8'h10, 8'h00, 8'hA5};

    // Loader works while held in reset.
    repeat (2) @(negedge clk);
    load(0, 8'h10, 8'hA5);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_out%0d", d), {rdata[d], ack[d], busy[d]}, 10'h000);
    end
    @(negedge clk);
    reset = 1'b1;

    txn(0, 1'b0, 8'h10, 8'h00, 2, "rd_preload");
    chk("rd_preload_data", rdata[0], 8'hA5);

    for (int i = 0; i < 11; i++) begin
      txn(0, vecs[i].w, vecs[i].a, vecs[i].wd, 2, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_rdata", i), rdata[0], vecs[i].exp);
    end

    // req held high: three reads back to back, IDLE cycle between acks.
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'h01; n_ack = 0;
    busy3 = 1'b1; busy6 = 1'b1;
    for (int c = 1; c <= 12 && n_ack < 3; c++) begin
      @(negedge clk);
      if (c == 3) busy3 = busy[0];
      if (c == 6) busy6 = busy[0];
      if (ack[0]) begin
        ack_at[n_ack] = c;
        ack_rd[n_ack] = rdata[0];
        n_ack++;
        addr[0] = 8'(n_ack + 1);
        if (n_ack == 3) req[0] = 1'b0;
      end
    end
    chk("b2b_count", n_ack, 3);
    for (int k = 0; k < n_ack; k++) begin
      chk($sformatf("b2b_at%0d", k), ack_at[k], 2 + 3 * k);
    end
    chk("b2b_rd0", ack_rd[0], 8'h11);
    chk("b2b_rd1", ack_rd[1], 8'h5A);
    chk("b2b_rd2", ack_rd[2], 8'h33);
    chk("b2b_idle", {busy3, busy6}, 2'b00);

    // CPU write and loader write to the same word on the same edge.
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h05; wdata[0] = 8'h11;
    @(negedge clk);
    req[0] = 1'b0; ld_en[0] = 1'b1; ld_addr[0] = 8'h05; ld_data[0] = 8'h22;
    @(negedge clk);
    ld_en[0] = 1'b0;
    chk("coll_wr_ack", ack[0], 1'b1);
    txn(0, 1'b0, 8'h05, 8'h00, 2, "coll_wr_rd");
    chk("coll_wr_data", rdata[0], 8'h22);

    // Read completing alongside a loader write returns old contents.
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 8'h05;
    @(negedge clk);
    req[0] = 1'b0; ld_en[0] = 1'b1; ld_addr[0] = 8'h05; ld_data[0] = 8'h99;
    @(negedge clk);
    ld_en[0] = 1'b0;
    chk("coll_rd_ack", ack[0], 1'b1);
    chk("coll_rd_old", rdata[0], 8'h22);
    txn(0, 1'b0, 8'h05, 8'h00, 2, "coll_rd_new");
    chk("coll_rd_new_data", rdata[0], 8'h99);

    // Zero wait states.
    txn(1, 1'b1, 8'h20, 8'h3C, 1, "w0_wr");
    chk("w0_wr_rdata", rdata[1], 8'h00);
    txn(1, 1'b0, 8'h20, 8'h00, 1, "w0_rd");
    chk("w0_rd_data", rdata[1], 8'h3C);

    // DEPTH=16 wraps addresses; three wait states.
    txn(2, 1'b1, 8'h13, 8'h77, 4, "d16_wr");
    txn(2, 1'b0, 8'h03, 8'h00, 4, "d16_rd");
    chk("d16_rd_data", rdata[2], 8'h77);
    txn(2, 1'b0, 8'hF3, 8'h00, 4, "d16_rd_hi");
    chk("d16_rd_hi_data", rdata[2], 8'h77);

    // Reset during WAIT of a write abandons it.
    load(0, 8'h07, 8'h5C);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'h07; wdata[0] = 8'hFF;
    @(negedge clk);
    req[0] = 1'b0;
    chk("abort_in_wait", busy[0], 1'b1);
    reset = 1'b0;
    #1;
    chk("abort_out", {rdata[0], ack[0], busy[0]}, 10'h000);
    seen_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ack[0]) seen_ack = 1'b1;
    end
    chk("abort_no_ack", seen_ack, 1'b0);
    reset = 1'b1;
    txn(0, 1'b0, 8'h07, 8'h00, 2, "abort_rd");
    chk("abort_mem_kept", rdata[0], 8'h5C);
    txn(0, 1'b0, 8'h10, 8'h00, 2, "post_rst_rd");
    chk("post_rst_mem", rdata[0], 8'hA5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
